// File: rtl/mem_access_unit.sv
// MEM stage of the pipeline: decodes loads/stores from EX-MEM, runs one req/gnt/rvalid bus
// access at a time, holds upstream while it is in flight and registers the MEM-WB result.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_addr_i,
   input  logic [31:0] reg_wdata_i,
   input  logic        reg_we_i,
   input  logic [4:0]  reg_waddr_i,
   input  logic [31:0] mem_addr_i,
   input  logic [1:0]  mem_raddr_index_i,
   input  logic [1:0]  mem_waddr_index_i,
   input  logic [31:0] reg2_rdata_i,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [31:0] dbus_wdata_o,
   output logic [3:0]  dbus_be_o,
   input  logic        dbus_gnt_i,
   input  logic        dbus_rvalid_i,
   input  logic [31:0] dbus_rdata_i,
   output logic        stall_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic [31:0] reg_wdata_o,
   output logic        reg_we_o,
   output logic [4:0]  reg_waddr_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam logic [31:0] INST_NOP     = 32'h0000_0013;
   localparam logic [6:0]  OPC_LOAD     = 7'b000_0011;
   localparam logic [6:0]  OPC_STORE    = 7'b010_0011;
   localparam logic [15:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t      state_reg;
   logic [15:0] cnt_reg;
   logic [2:0]  f3_reg;
   logic [1:0]  idx_reg;
   logic [4:0]  rd_reg;
   logic [31:0] inst_reg;
   logic [31:0] pc_reg;
   logic [31:0] alu_reg;
   logic [31:0] load_data_reg;
   logic        abort_reg;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_load;
   logic        is_store;
   logic        access_ok;
   logic        mem_valid;
   logic        mem_bad;
   logic [1:0]  acc_idx;
   logic [3:0]  acc_be;
   logic [31:0] st_wdata;
   logic [7:0]  rd_byte [4];
   logic [15:0] rd_half [2];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic        timeout_hit;
   logic        unused_addr_bits;

   assign opcode   = inst_i[6:0];
   assign funct3   = inst_i[14:12];
   assign is_load  = (opcode == OPC_LOAD);
   assign is_store = (opcode == OPC_STORE);

   // The word address drops the low bits; the byte position comes from the index inputs.
   assign unused_addr_bits = ^mem_addr_i[1:0];

   always_comb begin
      access_ok = 1'b0;
      if (is_load) begin
         case (funct3)
            3'b000, 3'b100: access_ok = 1'b1;
            3'b001, 3'b101: access_ok = ~mem_raddr_index_i[0];
            3'b010:         access_ok = (mem_raddr_index_i == 2'b00);
            default:        access_ok = 1'b0;
         endcase
      end else if (is_store) begin
         case (funct3)
            3'b000:  access_ok = 1'b1;
            3'b001:  access_ok = ~mem_waddr_index_i[0];
            3'b010:  access_ok = (mem_waddr_index_i == 2'b00);
            default: access_ok = 1'b0;
         endcase
      end
   end

   assign mem_valid = (is_load | is_store) & access_ok;
   assign mem_bad   = (is_load | is_store) & ~access_ok;

   always_comb begin
      acc_idx  = is_store ? mem_waddr_index_i : mem_raddr_index_i;
      acc_be   = 4'b1111;
      st_wdata = reg2_rdata_i;
      case (funct3[1:0])
         2'b00: begin
            acc_be   = 4'b0001 << acc_idx;
            st_wdata = {4{reg2_rdata_i[7:0]}};
         end
         2'b01: begin
            acc_be   = 4'b0011 << acc_idx;
            st_wdata = {2{reg2_rdata_i[15:0]}};
         end
         default: begin
            acc_be   = 4'b1111;
            st_wdata = reg2_rdata_i;
         end
      endcase
   end

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign rd_byte[gi] = dbus_rdata_i[8*gi +: 8];
   end
   for (gi = 0; gi < 2; gi++) begin : g_half_lane
      assign rd_half[gi] = dbus_rdata_i[16*gi +: 16];
   end

   // Extraction uses the latched size and byte index, since inst_i may be a new op by then.
   always_comb begin
      byte_sel = rd_byte[idx_reg];
      half_sel = rd_half[idx_reg[1]];
      case (f3_reg)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = dbus_rdata_i;
      endcase
   end

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg >= TIMEOUT_LAST);

   assign stall_o = ~rst & (((state_reg == IDLE) & mem_valid) | (state_reg == REQ) | (state_reg == RESP));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= 16'd0;
         f3_reg        <= 3'd0;
         idx_reg       <= 2'd0;
         rd_reg        <= 5'd0;
         inst_reg      <= 32'd0;
         pc_reg        <= 32'd0;
         alu_reg       <= 32'd0;
         load_data_reg <= 32'd0;
         abort_reg     <= 1'b0;
         dbus_req_o    <= 1'b0;
         dbus_we_o     <= 1'b0;
         dbus_addr_o   <= 32'd0;
         dbus_wdata_o  <= 32'd0;
         dbus_be_o     <= 4'd0;
         inst_o        <= INST_NOP;
         inst_addr_o   <= 32'd0;
         reg_wdata_o   <= 32'd0;
         reg_we_o      <= 1'b0;
         reg_waddr_o   <= 5'd0;
         misalign_o    <= 1'b0;
         bus_err_o     <= 1'b0;
      end else begin
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (mem_valid) begin
                  dbus_req_o   <= 1'b1;
                  dbus_we_o    <= is_store;
                  dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                  dbus_wdata_o <= st_wdata;
                  dbus_be_o    <= acc_be;
                  f3_reg       <= funct3;
                  idx_reg      <= acc_idx;
                  rd_reg       <= reg_waddr_i;
                  inst_reg     <= inst_i;
                  pc_reg       <= inst_addr_i;
                  alu_reg      <= reg_wdata_i;
                  abort_reg    <= 1'b0;
                  cnt_reg      <= 16'd0;
                  inst_o       <= INST_NOP;
                  reg_we_o     <= 1'b0;
                  state_reg    <= REQ;
               end else begin
                  inst_o      <= inst_i;
                  inst_addr_o <= inst_addr_i;
                  reg_wdata_o <= reg_wdata_i;
                  reg_waddr_o <= reg_waddr_i;
                  reg_we_o    <= reg_we_i & ~mem_bad;
                  misalign_o  <= mem_bad;
               end
            end
            REQ: begin
               if (dbus_gnt_i) begin
                  dbus_req_o <= 1'b0;
                  cnt_reg    <= cnt_reg + 16'd1;
                  state_reg  <= dbus_we_o ? DONE : RESP;
               end else if (timeout_hit) begin
                  dbus_req_o <= 1'b0;
                  bus_err_o  <= 1'b1;
                  abort_reg  <= 1'b1;
                  state_reg  <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            RESP: begin
               if (dbus_rvalid_i) begin
                  load_data_reg <= load_ext;
                  state_reg     <= DONE;
               end else if (timeout_hit) begin
                  bus_err_o <= 1'b1;
                  abort_reg <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            DONE: begin
               inst_o      <= inst_reg;
               inst_addr_o <= pc_reg;
               reg_waddr_o <= rd_reg;
               reg_wdata_o <= dbus_we_o ? alu_reg : load_data_reg;
               // Stores, aborted loads and loads to x0 retire without a register write.
               reg_we_o    <= ~dbus_we_o & ~abort_reg & (rd_reg != 5'd0);
               abort_reg   <= 1'b0;
               state_reg   <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: acts as EX-MEM driver and data-bus slave, checks WB results.
module tb_mem_access_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] ADD = {7'd0, 5'd2, 5'd1, 3'b000, 5'd5, 7'b011_0011};

   logic        clk;
   logic        rst;
   logic [31:0] inst_i;
   logic [31:0] inst_addr_i;
   logic [31:0] reg_wdata_i;
   logic        reg_we_i;
   logic [4:0]  reg_waddr_i;
   logic [31:0] mem_addr_i;
   logic [1:0]  mem_raddr_index_i;
   logic [1:0]  mem_waddr_index_i;
   logic [31:0] reg2_rdata_i;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [31:0] dbus_wdata_o;
   logic [3:0]  dbus_be_o;
   logic        dbus_gnt_i;
   logic        dbus_rvalid_i;
   logic [31:0] dbus_rdata_i;
   logic        stall_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic [31:0] reg_wdata_o;
   logic        reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic        misalign_o;
   logic        bus_err_o;

   int          checks = 0;
   int          errors = 0;
   int          st_cycles;
   int          rq_cycles;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_we;
   logic [31:0] pc = 32'h100;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .inst_i            (inst_i),
      .inst_addr_i       (inst_addr_i),
      .reg_wdata_i       (reg_wdata_i),
      .reg_we_i          (reg_we_i),
      .reg_waddr_i       (reg_waddr_i),
      .mem_addr_i        (mem_addr_i),
      .mem_raddr_index_i (mem_raddr_index_i),
      .mem_waddr_index_i (mem_waddr_index_i),
      .reg2_rdata_i      (reg2_rdata_i),
      .dbus_req_o        (dbus_req_o),
      .dbus_we_o         (dbus_we_o),
      .dbus_addr_o       (dbus_addr_o),
      .dbus_wdata_o      (dbus_wdata_o),
      .dbus_be_o         (dbus_be_o),
      .dbus_gnt_i        (dbus_gnt_i),
      .dbus_rvalid_i     (dbus_rvalid_i),
      .dbus_rdata_i      (dbus_rdata_i),
      .stall_o           (stall_o),
      .inst_o            (inst_o),
      .inst_addr_o       (inst_addr_o),
      .reg_wdata_o       (reg_wdata_o),
      .reg_we_o          (reg_we_o),
      .reg_waddr_o       (reg_waddr_o),
      .misalign_o        (misalign_o),
      .bus_err_o         (bus_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_load(input logic [2:0] f3, input logic [4:0] rd);
      return {12'h010, 5'd1, f3, rd, 7'b000_0011};
   endfunction

   function automatic logic [31:0] mk_store(input logic [2:0] f3);
      return {7'd0, 5'd2, 5'd1, f3, 5'd4, 7'b010_0011};
   endfunction

   task automatic drive_idle();
      inst_i            = NOP;
      inst_addr_i       = 32'd0;
      reg_wdata_i       = 32'd0;
      reg_we_i          = 1'b0;
      reg_waddr_i       = 5'd0;
      mem_addr_i        = 32'd0;
      mem_raddr_index_i = 2'd0;
      mem_waddr_index_i = 2'd0;
      reg2_rdata_i      = 32'd0;
   endtask

   // Presents one instruction and serves the bus until stall_o drops (bounded).
   task automatic run_access(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                             input logic [4:0] rd, input logic [31:0] rs2, input int gnt_wait,
                             input int rv_wait, input logic [31:0] rdata);
      bit done;
      bit resp_phase;
      int resp_cnt;
      done       = 1'b0;
      resp_phase = 1'b0;
      resp_cnt   = 0;
      pc         = pc + 32'd4;
      inst_i            = inst;
      inst_addr_i       = pc;
      reg_wdata_i       = addr ^ 32'h0000_5A00;
      reg_we_i          = 1'b1;
      reg_waddr_i       = rd;
      mem_addr_i        = addr;
      mem_raddr_index_i = addr[1:0];
      mem_waddr_index_i = addr[1:0];
      reg2_rdata_i      = rs2;
      dbus_rdata_i      = rdata;
      st_cycles = 0;
      rq_cycles = 0;
      cap_addr  = 32'd0;
      cap_wdata = 32'd0;
      cap_be    = 4'd0;
      cap_we    = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         #1;
         if (!stall_o) begin
            done = 1'b1;
         end else begin
            st_cycles++;
            dbus_rvalid_i = 1'b0;
            if (resp_phase) begin
               resp_cnt++;
               if (resp_cnt > rv_wait) begin
                  dbus_rvalid_i = 1'b1;
                  resp_phase    = 1'b0;
               end
            end
            dbus_gnt_i = 1'b0;
            if (dbus_req_o) begin
               rq_cycles++;
               if (rq_cycles > gnt_wait) begin
                  dbus_gnt_i = 1'b1;
                  cap_addr   = dbus_addr_o;
                  cap_wdata  = dbus_wdata_o;
                  cap_be     = dbus_be_o;
                  cap_we     = dbus_we_o;
                  resp_phase = ~dbus_we_o;
                  resp_cnt   = 0;
               end
            end
            tick();
         end
      end
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b0;
      check({tag, "_bound"}, {31'd0, done}, 32'd1);
   endtask

   task automatic wb_expect(input string tag, input logic [31:0] exp_inst, input bit chk_data,
                            input logic [31:0] exp_data, input logic exp_we, input logic [4:0] exp_waddr,
                            input logic exp_mis);
      tick();
      drive_idle();
      check({tag, "_inst"}, inst_o, exp_inst);
      check({tag, "_pc"}, inst_addr_o, pc);
      if (chk_data) check({tag, "_wdata"}, reg_wdata_o, exp_data);
      check({tag, "_we"}, {31'd0, reg_we_o}, {31'd0, exp_we});
      if (exp_we) check({tag, "_waddr"}, {27'd0, reg_waddr_o}, {27'd0, exp_waddr});
      check({tag, "_misalign"}, {31'd0, misalign_o}, {31'd0, exp_mis});
      check({tag, "_buserr"}, {31'd0, bus_err_o}, 32'd0);
      $display("txn %s: stall=%0d req=%0d wb_data=0x%08h we=%b", tag, st_cycles, rq_cycles, reg_wdata_o, reg_we_o);
   endtask

   initial begin
      rst           = 1'b1;
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b0;
      dbus_rdata_i  = 32'd0;
      drive_idle();
      #3;
      check("rst_inst", inst_o, NOP);
      check("rst_we", {31'd0, reg_we_o}, 32'd0);
      check("rst_req", {31'd0, dbus_req_o}, 32'd0);
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      check("rst_wdata", reg_wdata_o, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      run_access("add", ADD, 32'h0, 5'd5, 32'd0, 0, 0, 32'd0);
      reg_wdata_i = 32'h1234;
      check("add_stall", st_cycles, 0);
      wb_expect("add", ADD, 1'b1, 32'h1234, 1'b1, 5'd5, 1'b0);
      check("add_req", {31'd0, dbus_req_o}, 32'd0);

      run_access("lb", mk_load(3'b000, 5'd7), 32'h2003, 5'd7, 32'd0, 1, 0, 32'h80FF_0000);
      check("lb_stall", st_cycles, 4);
      check("lb_req", rq_cycles, 2);
      check("lb_addr", cap_addr, 32'h2000);
      check("lb_we", {31'd0, cap_we}, 32'd0);
      wb_expect("lb", mk_load(3'b000, 5'd7), 1'b1, 32'hFFFF_FF80, 1'b1, 5'd7, 1'b0);

      run_access("lbu", mk_load(3'b100, 5'd8), 32'h2003, 5'd8, 32'd0, 1, 0, 32'h80FF_0000);
      check("lbu_stall", st_cycles, 4);
      wb_expect("lbu", mk_load(3'b100, 5'd8), 1'b1, 32'h0000_0080, 1'b1, 5'd8, 1'b0);

      run_access("lh", mk_load(3'b001, 5'd9), 32'h2002, 5'd9, 32'd0, 0, 0, 32'h80FF_0000);
      check("lh_stall", st_cycles, 3);
      wb_expect("lh", mk_load(3'b001, 5'd9), 1'b1, 32'hFFFF_80FF, 1'b1, 5'd9, 1'b0);

      run_access("lhu", mk_load(3'b101, 5'd10), 32'h2000, 5'd10, 32'd0, 0, 0, 32'h1234_8001);
      wb_expect("lhu", mk_load(3'b101, 5'd10), 1'b1, 32'h0000_8001, 1'b1, 5'd10, 1'b0);

      run_access("lw", mk_load(3'b010, 5'd11), 32'h3000, 5'd11, 32'd0, 0, 2, 32'hDEAD_BEEF);
      check("lw_stall", st_cycles, 5);
      wb_expect("lw", mk_load(3'b010, 5'd11), 1'b1, 32'hDEAD_BEEF, 1'b1, 5'd11, 1'b0);

      run_access("sh", mk_store(3'b001), 32'h1002, 5'd0, 32'hABCD_1234, 1, 0, 32'd0);
      check("sh_stall", st_cycles, 3);
      check("sh_addr", cap_addr, 32'h1000);
      check("sh_be", {28'd0, cap_be}, 32'hC);
      check("sh_wdata", cap_wdata, 32'h1234_1234);
      check("sh_we", {31'd0, cap_we}, 32'd1);
      wb_expect("sh", mk_store(3'b001), 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);

      run_access("sb", mk_store(3'b000), 32'h1005, 5'd0, 32'h0000_00A5, 0, 0, 32'd0);
      check("sb_addr", cap_addr, 32'h1004);
      check("sb_be", {28'd0, cap_be}, 32'h2);
      check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
      wb_expect("sb", mk_store(3'b000), 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);

      run_access("sw", mk_store(3'b010), 32'h4000, 5'd0, 32'hCAFE_F00D, 0, 0, 32'd0);
      check("sw_be", {28'd0, cap_be}, 32'hF);
      check("sw_wdata", cap_wdata, 32'hCAFE_F00D);
      wb_expect("sw", mk_store(3'b010), 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);

      run_access("lw_x0", mk_load(3'b010, 5'd0), 32'h3004, 5'd0, 32'd0, 0, 0, 32'h0000_0001);
      check("lw_x0_req", rq_cycles, 1);
      wb_expect("lw_x0", mk_load(3'b010, 5'd0), 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);

      run_access("mis_lw", mk_load(3'b010, 5'd12), 32'h1001, 5'd12, 32'd0, 0, 0, 32'd0);
      check("mis_lw_stall", st_cycles, 0);
      wb_expect("mis_lw", mk_load(3'b010, 5'd12), 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      check("mis_lw_req", {31'd0, dbus_req_o}, 32'd0);
      tick();
      check("mis_lw_pulse", {31'd0, misalign_o}, 32'd0);

      run_access("mis_lh", mk_load(3'b001, 5'd13), 32'h1003, 5'd13, 32'd0, 0, 0, 32'd0);
      wb_expect("mis_lh", mk_load(3'b001, 5'd13), 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      run_access("mis_sw", mk_store(3'b010), 32'h1002, 5'd0, 32'h1, 0, 0, 32'd0);
      wb_expect("mis_sw", mk_store(3'b010), 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      run_access("bad_f3", mk_load(3'b011, 5'd14), 32'h1000, 5'd14, 32'd0, 0, 0, 32'd0);
      check("bad_f3_req", rq_cycles, 0);
      wb_expect("bad_f3", mk_load(3'b011, 5'd14), 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);

      run_access("tmo_req", mk_load(3'b010, 5'd15), 32'h5000, 5'd15, 32'd0, 100, 0, 32'd0);
      check("tmo_req_cycles", rq_cycles, 4);
      check("tmo_req_stall", st_cycles, 5);
      check("tmo_req_err", {31'd0, bus_err_o}, 32'd1);
      check("tmo_req_reqlow", {31'd0, dbus_req_o}, 32'd0);
      wb_expect("tmo_req", mk_load(3'b010, 5'd15), 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);

      run_access("tmo_resp", mk_load(3'b010, 5'd16), 32'h5004, 5'd16, 32'd0, 0, 100, 32'd0);
      check("tmo_resp_stall", st_cycles, 5);
      check("tmo_resp_err", {31'd0, bus_err_o}, 32'd1);
      wb_expect("tmo_resp", mk_load(3'b010, 5'd16), 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);

      // Reset while the request is pending.
      inst_i = mk_load(3'b010, 5'd17); reg_we_i = 1'b1; reg_waddr_i = 5'd17; mem_addr_i = 32'h6000;
      #1;
      check("rst_req_stall_pre", {31'd0, stall_o}, 32'd1);
      tick();
      check("rst_req_req_pre", {31'd0, dbus_req_o}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_req_req", {31'd0, dbus_req_o}, 32'd0);
      check("rst_req_stall", {31'd0, stall_o}, 32'd0);
      check("rst_req_we", {31'd0, reg_we_o}, 32'd0);
      drive_idle();
      tick();
      rst = 1'b0;
      tick();
      $display("txn rst_in_req: request dropped");

      // Reset while waiting for read data.
      inst_i = mk_load(3'b010, 5'd18); reg_we_i = 1'b1; reg_waddr_i = 5'd18; mem_addr_i = 32'h6004;
      tick();
      dbus_gnt_i = 1'b1;
      tick();
      dbus_gnt_i = 1'b0;
      #1;
      check("rst_resp_stall_pre", {31'd0, stall_o}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_resp_req", {31'd0, dbus_req_o}, 32'd0);
      check("rst_resp_stall", {31'd0, stall_o}, 32'd0);
      check("rst_resp_we", {31'd0, reg_we_o}, 32'd0);
      drive_idle();
      tick();
      rst = 1'b0;
      tick();
      $display("txn rst_in_resp: access abandoned");

      run_access("post_rst", mk_load(3'b010, 5'd19), 32'h7000, 5'd19, 32'd0, 0, 0, 32'h0102_0304);
      check("post_rst_stall", st_cycles, 3);
      wb_expect("post_rst", mk_load(3'b010, 5'd19), 1'b1, 32'h0102_0304, 1'b1, 5'd19, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
